// File: rtl/blue_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blue_motion_pkg
// Purpose  : Shared game definitions used by the blue-block motion logic and
//            by the collision logic. Holds the sprite size, the vertical state
//            encoding, the frame-update sequencer encoding and a helper.
// Revision : 1.0 - initial release
// ============================================================================
package blue_motion_pkg;

    // Blue sprite size in pixels
    localparam int unsigned BLUE_W = 23;
    localparam int unsigned BLUE_H = 45;

    // Vertical motion state as seen on the v_state port
    typedef enum logic [1:0] {
        VS_GROUND = 2'b00,
        VS_RISE   = 2'b01,
        VS_FALL   = 2'b10
    } vstate_t;

    // Frame-update sequencer: each pixel step is a STEP cycle followed by a
    // SETTLE cycle so the registered collision flags catch up before the
    // next step decision is taken.
    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_HSTEP   = 3'd1,
        SEQ_HSETTLE = 3'd2,
        SEQ_VSTEP   = 3'd3,
        SEQ_VSETTLE = 3'd4,
        SEQ_DONE    = 3'd5
    } seq_state_t;

    // Saturating 4-bit increment
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        return (v < lim) ? (v + 4'd1) : lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blue_step_seq.sv
`default_nettype none
// ============================================================================
// Module   : blue_step_seq
// Purpose  : Two-clock step/settle sequencer for one frame update. Runs the
//            horizontal steps, then the vertical steps, then a one-cycle DONE.
//            It owns the 4-bit step counter and emits one strobe per event;
//            the physics itself lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module blue_step_seq
    import blue_motion_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,       // frame tick, accepted only when idle
    input  logic [3:0] i_h_cnt,       // horizontal step count for this frame
    input  logic       i_h_block,     // horizontal move not allowed now
    input  logic [3:0] i_v_cnt,       // vertical step count (after state update)
    input  logic       i_v_block,     // vertical collision / limit reached
    output logic       o_h_step,      // move one pixel horizontally
    output logic       o_h_end,       // horizontal phase over: update v-state
    output logic       o_v_step,      // move one pixel vertically
    output logic       o_v_hit,       // immediate vertical transition
    output logic       o_v_end,       // all vertical steps done: end-of-frame
    output logic       o_busy,
    output logic       o_frame_done
);

    seq_state_t r_state;
    seq_state_t w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_cnt_zero;

    assign w_cnt_zero   = (r_cnt == 4'd0);
    assign o_busy       = (r_state != SEQ_IDLE);
    assign o_frame_done = (r_state == SEQ_DONE);

    // Sequencer state and step counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_h_step     = 1'b0;
        o_h_end      = 1'b0;
        o_v_step     = 1'b0;
        o_v_hit      = 1'b0;
        o_v_end      = 1'b0;
        unique case (r_state)
            SEQ_IDLE: begin
                if (i_start) begin
                    w_state_next = SEQ_HSTEP;
                    w_cnt_next   = i_h_cnt;
                end
            end
            SEQ_HSTEP: begin
                if (!w_cnt_zero && !i_h_block) begin
                    o_h_step     = 1'b1;
                    w_cnt_next   = r_cnt - 4'd1;
                    w_state_next = SEQ_HSETTLE;
                end else begin
                    o_h_end      = 1'b1;
                    w_cnt_next   = i_v_cnt;
                    w_state_next = SEQ_VSTEP;
                end
            end
            SEQ_HSETTLE: begin
                w_state_next = SEQ_HSTEP;
            end
            SEQ_VSTEP: begin
                if (i_v_block) begin
                    // Hit is checked before the count so the final step of a
                    // frame still gets its collision response this frame.
                    o_v_hit      = 1'b1;
                    w_cnt_next   = 4'd0;
                    w_state_next = SEQ_DONE;
                end else if (w_cnt_zero) begin
                    o_v_end      = 1'b1;
                    w_state_next = SEQ_DONE;
                end else begin
                    o_v_step     = 1'b1;
                    w_cnt_next   = r_cnt - 4'd1;
                    w_state_next = SEQ_VSETTLE;
                end
            end
            SEQ_VSETTLE: begin
                w_state_next = SEQ_VSTEP;
            end
            SEQ_DONE: begin
                w_state_next = SEQ_IDLE;
            end
            default: begin
                w_state_next = SEQ_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/blue_motion.sv
`default_nettype none
// ============================================================================
// Module   : blue_motion
// Purpose  : Per-frame motion of the blue block: horizontal walking from the
//            buttons and vertical ground/rise/fall physics, one pixel per
//            step so registered collision flags are never overshot.
// Revision : 1.0 - initial release
// ============================================================================
module blue_motion
    import blue_motion_pkg::*;
#(
    parameter logic [9:0] X_INIT = 10'd40,
    parameter logic [8:0] Y_INIT = 9'd300,
    parameter logic [9:0] X_MAX  = 10'd617,
    parameter logic [8:0] Y_MAX  = 9'd435,
    parameter logic [3:0] JUMP_V = 4'd8,
    parameter logic [3:0] V_MAX  = 4'd8,
    parameter logic [3:0] STEP_X = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic [3:0] is_Collision,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [1:0] v_state,
    output logic       busy,
    output logic       frame_done
);

    logic [9:0] r_x;
    logic [8:0] r_y;
    vstate_t    r_vs;
    logic [3:0] r_vel;
    logic       r_dir_right;
    logic       r_jump;

    logic       w_start;
    logic [3:0] w_h_cnt;
    logic       w_h_block;
    logic       w_v_block;
    vstate_t    w_vs_start;
    logic [3:0] w_vel_start;
    logic       w_h_step;
    logic       w_h_end;
    logic       w_v_step;
    logic       w_v_hit;
    logic       w_v_end;

    assign x_blue  = r_x;
    assign y_blue  = r_y;
    assign v_state = r_vs;

    // A tick is only taken when idle; ticks during an update are dropped
    assign w_start = frame_tick & ~busy;

    // Both or neither button pressed means no horizontal motion
    assign w_h_cnt = (btn_left ^ btn_right) ? STEP_X : 4'd0;

    // Stop walking on a side collision or at the screen edge
    assign w_h_block = r_dir_right ? (is_Collision[2] | (r_x >= X_MAX))
                                   : (is_Collision[3] | (r_x == 10'd0));

    // Once-per-frame ground decision taken when the horizontal phase ends
    always_comb begin
        w_vs_start  = r_vs;
        w_vel_start = r_vel;
        if (r_vs == VS_GROUND) begin
            if (r_jump) begin
                w_vs_start  = VS_RISE;
                w_vel_start = JUMP_V;
            end else if (!is_Collision[0]) begin
                w_vs_start  = VS_FALL;
                w_vel_start = 4'd1;
            end else begin
                w_vel_start = 4'd0;
            end
        end
    end

    // Immediate vertical stop conditions for the current direction
    always_comb begin
        w_v_block = 1'b0;
        unique case (r_vs)
            VS_RISE: w_v_block = is_Collision[1] | (r_y == 9'd0);
            VS_FALL: w_v_block = is_Collision[0] | (r_y >= Y_MAX);
            default: w_v_block = 1'b0;
        endcase
    end

    blue_step_seq u_seq (
        .clk          (clk),
        .rst          (rst),
        .i_start      (frame_tick),
        .i_h_cnt      (w_h_cnt),
        .i_h_block    (w_h_block),
        .i_v_cnt      (w_vel_start),
        .i_v_block    (w_v_block),
        .o_h_step     (w_h_step),
        .o_h_end      (w_h_end),
        .o_v_step     (w_v_step),
        .o_v_hit      (w_v_hit),
        .o_v_end      (w_v_end),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    // Position, velocity and latched-button registers driven by sequencer strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= X_INIT;
            r_y         <= Y_INIT;
            r_vs        <= VS_FALL;
            r_vel       <= 4'd1;
            r_dir_right <= 1'b0;
            r_jump      <= 1'b0;
        end else begin
            if (w_start) begin
                r_dir_right <= btn_right;
                r_jump      <= btn_jump;
            end
            if (w_h_step) begin
                r_x <= r_dir_right ? (r_x + 10'd1) : (r_x - 10'd1);
            end
            if (w_h_end) begin
                r_vs  <= w_vs_start;
                r_vel <= w_vel_start;
            end
            if (w_v_step) begin
                r_y <= (r_vs == VS_RISE) ? (r_y - 9'd1) : (r_y + 9'd1);
            end
            if (w_v_hit) begin
                if (r_vs == VS_RISE) begin
                    r_vs  <= VS_FALL;
                    r_vel <= 4'd1;
                end else begin
                    r_vs  <= VS_GROUND;
                    r_vel <= 4'd0;
                end
            end
            if (w_v_end) begin
                if (r_vs == VS_RISE) begin
                    // Speed runs out at the apex: start falling next frame
                    if (r_vel <= 4'd1) begin
                        r_vs  <= VS_FALL;
                        r_vel <= 4'd1;
                    end else begin
                        r_vel <= r_vel - 4'd1;
                    end
                end else if (r_vs == VS_FALL) begin
                    r_vel <= sat_inc4(r_vel, V_MAX);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blue_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_blue_motion
// Purpose  : Self-checking bench for blue_motion. A simple collision
//            environment (floor, ceiling, walls) produces registered flags
//            from the block position; a frame-level reference model predicts
//            position and vertical state after every frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blue_motion;

    localparam int XI = 40;
    localparam int YI = 300;
    localparam int XM = 617;
    localparam int YM = 435;
    localparam int JV = 8;
    localparam int VM = 8;
    localparam int SX = 2;
    localparam int GROUND = 0;
    localparam int RISE   = 1;
    localparam int FALL   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [3:0] is_Collision;
    logic [9:0] x_blue;
    logic [8:0] y_blue;
    logic [1:0] v_state;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    // Environment geometry
    bit floor_en, ceil_en, wr_en, wl_en;
    int floor_y, ceil_y, wall_r, wall_l;

    // Reference model state
    int mx, my, mvs, mvel;

    blue_motion dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .is_Collision (is_Collision),
        .x_blue       (x_blue),
        .y_blue       (y_blue),
        .v_state      (v_state),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Registered collision flags, one cycle behind the position
    always @(posedge clk) begin
        is_Collision <= {wl_en && (int'(x_blue) <= wall_l),
                         wr_en && (int'(x_blue) >= wall_r),
                         ceil_en && (int'(y_blue) <= ceil_y),
                         floor_en && (int'(y_blue) >= floor_y)};
    end

    task automatic model_reset;
        mx = XI; my = YI; mvs = FALL; mvel = 1;
    endtask

    // One whole frame computed from the motion rules directly
    task automatic model_frame(input bit l, input bit r, input bit j);
        int lim;
        if (l != r) begin
            if (r) begin
                lim = (wr_en && wall_r < XM) ? wall_r : XM;
                if (mx < lim) mx = (mx + SX < lim) ? mx + SX : lim;
            end else begin
                lim = (wl_en && wall_l > 0) ? wall_l : 0;
                if (mx > lim) mx = (mx - SX > lim) ? mx - SX : lim;
            end
        end
        if (mvs == GROUND) begin
            if (j) begin
                mvs = RISE; mvel = JV;
            end else if (!(floor_en && my >= floor_y)) begin
                mvs = FALL; mvel = 1;
            end else begin
                mvel = 0;
            end
        end
        if (mvs == RISE) begin
            lim = (ceil_en && ceil_y > 0) ? ceil_y : 0;
            if (my <= lim + mvel) begin
                if (my > lim) my = lim;
                mvs = FALL; mvel = 1;
            end else begin
                my = my - mvel;
                if (mvel == 1) mvs = FALL;
                else mvel = mvel - 1;
            end
        end else if (mvs == FALL) begin
            lim = (floor_en && floor_y < YM) ? floor_y : YM;
            if (my + mvel >= lim) begin
                if (my < lim) my = lim;
                mvs = GROUND; mvel = 0;
            end else begin
                my = my + mvel;
                mvel = (mvel < VM) ? mvel + 1 : VM;
            end
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic env_clear;
        floor_en = 0; ceil_en = 0; wr_en = 0; wl_en = 0;
        floor_y = 1000; ceil_y = -1; wall_r = 1000; wall_l = -1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic settle;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drives one frame and reports whether the handshake behaved
    task automatic run_frame(input bit l, input bit r, input bit j, output bit ok);
        int n;
        bit busy_seen, done_seen, tidy;
        model_frame(l, r, j);
        btn_left = l; btn_right = r; btn_jump = j;
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        busy_seen = (busy === 1'b1);
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        done_seen = (frame_done === 1'b1);
        @(posedge clk);
        #1;
        tidy = (frame_done === 1'b0) && (busy === 1'b0);
        btn_left = 0; btn_right = 0; btn_jump = 0;
        ok = busy_seen && done_seen && tidy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        frame_tick = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
        env_clear();
        apply_reset();
        total++; if (x_blue !== 10'd40) begin bad++; $display("FAIL reset_x got=%0d want=40", x_blue); end
        total++; if (y_blue !== 9'd300) begin bad++; $display("FAIL reset_y got=%0d want=300", y_blue); end
        total++; if (v_state !== 2'b10) begin bad++; $display("FAIL reset_vstate got=%b want=10", v_state); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    endtask

    task automatic test_freefall;
        int exp_d [11];
        int prev;
        bit ok;
        exp_d = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8};
        apply_reset();
        for (int f = 0; f < 11; f++) begin
            prev = int'(y_blue);
            run_frame(0, 0, 0, ok);
            total++; if (!ok) begin bad++; $display("FAIL freefall_handshake frame=%0d got=bad want=busy/done/idle", f); end
            total++; if (int'(y_blue) - prev != exp_d[f]) begin bad++; $display("FAIL freefall_dy frame=%0d got=%0d want=%0d", f, int'(y_blue) - prev, exp_d[f]); end
            total++; if ({x_blue, y_blue, v_state} !== {10'(mx), 9'(my), 2'(mvs)}) begin bad++; $display("FAIL freefall_pos frame=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", f, x_blue, y_blue, v_state, mx, my, mvs); end
        end
    endtask

    task automatic test_land;
        bit ok;
        apply_reset();
        floor_en = 1; floor_y = 310;
        settle();
        for (int f = 0; f < 6; f++) begin
            run_frame(0, 0, 0, ok);
            total++; if (!ok) begin bad++; $display("FAIL land_handshake frame=%0d got=bad want=busy/done/idle", f); end
            total++; if ({x_blue, y_blue, v_state} !== {10'(mx), 9'(my), 2'(mvs)}) begin bad++; $display("FAIL land_pos frame=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", f, x_blue, y_blue, v_state, mx, my, mvs); end
        end
        total++; if (y_blue !== 9'd310 || v_state !== 2'b00) begin bad++; $display("FAIL land_final got=(%0d,%b) want=(310,00)", y_blue, v_state); end
    endtask

    task automatic test_jump;
        int prev;
        bit ok;
        for (int f = 0; f < 8; f++) begin
            prev = int'(y_blue);
            run_frame(0, 0, f == 0, ok);
            total++; if (!ok) begin bad++; $display("FAIL jump_handshake frame=%0d got=bad want=busy/done/idle", f); end
            total++; if (prev - int'(y_blue) != 8 - f) begin bad++; $display("FAIL jump_dy frame=%0d got=%0d want=%0d", f, prev - int'(y_blue), 8 - f); end
            total++; if (v_state !== ((f == 7) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL jump_vstate frame=%0d got=%b want=%b", f, v_state, (f == 7) ? 2'b10 : 2'b01); end
        end
        for (int f = 0; f < 20 && mvs != GROUND; f++) begin
            run_frame(0, 0, 0, ok);
            total++; if (!ok || {x_blue, y_blue, v_state} !== {10'(mx), 9'(my), 2'(mvs)}) begin bad++; $display("FAIL jump_return frame=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d) ok=%0d", f, x_blue, y_blue, v_state, mx, my, mvs, ok); end
        end
    endtask

    task automatic test_ceiling;
        bit ok;
        ceil_en = 1; ceil_y = 307;
        settle();
        run_frame(0, 0, 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL ceil_handshake got=bad want=busy/done/idle"); end
        total++; if (y_blue !== 9'd307 || v_state !== 2'b10) begin bad++; $display("FAIL ceil_hit got=(%0d,%b) want=(307,10)", y_blue, v_state); end
        run_frame(0, 0, 0, ok);
        total++; if (y_blue !== 9'd308 || y_blue !== 9'(my)) begin bad++; $display("FAIL ceil_after got=%0d want=308 model=%0d", y_blue, my); end
    endtask

    task automatic test_horizontal;
        int prev;
        bit ok;
        apply_reset();
        env_clear();
        prev = int'(x_blue);
        for (int f = 0; f < 320 && x_blue !== 10'd617; f++) begin
            prev = int'(x_blue);
            run_frame(0, 1, 0, ok);
            total++; if (!ok || {x_blue, y_blue, v_state} !== {10'(mx), 9'(my), 2'(mvs)}) begin bad++; $display("FAIL walk_right frame=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d) ok=%0d", f, x_blue, y_blue, v_state, mx, my, mvs, ok); end
        end
        total++; if (x_blue !== 10'd617 || prev != 616) begin bad++; $display("FAIL right_saturate got=%0d from=%0d want=617 from=616", x_blue, prev); end
        run_frame(1, 1, 0, ok);
        total++; if (x_blue !== 10'd617) begin bad++; $display("FAIL both_buttons got=%0d want=617", x_blue); end
        for (int f = 0; f < 3; f++) run_frame(1, 0, 0, ok);
        total++; if (x_blue !== 10'd611 || x_blue !== 10'(mx)) begin bad++; $display("FAIL walk_left got=%0d want=611 model=%0d", x_blue, mx); end
        wr_en = 1; wall_r = 611;
        settle();
        run_frame(0, 1, 0, ok);
        total++; if (x_blue !== 10'd611) begin bad++; $display("FAIL right_wall got=%0d want=611", x_blue); end
        run_frame(1, 0, 0, ok);
        total++; if (x_blue !== 10'd609) begin bad++; $display("FAIL left_after_wall got=%0d want=609", x_blue); end
    endtask

    task automatic test_busy_tick;
        int n, busy_cycles;
        bit ok;
        apply_reset();
        env_clear();
        model_frame(0, 1, 0);
        btn_right = 1;
        frame_tick = 1;
        @(posedge clk);
        #1 frame_tick = 0;
        @(posedge clk);
        #1 frame_tick = 1;
        @(posedge clk);
        #1 frame_tick = 0;
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL busy_tick_timeout got=%b want=1", frame_done); end
        busy_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 if (busy === 1'b1) busy_cycles++;
        end
        btn_right = 0;
        total++; if (busy_cycles != 0) begin bad++; $display("FAIL busy_tick_queued got=%0d busy cycles want=0", busy_cycles); end
        total++; if ({x_blue, y_blue, v_state} !== {10'(mx), 9'(my), 2'(mvs)}) begin bad++; $display("FAIL busy_tick_pos got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", x_blue, y_blue, v_state, mx, my, mvs); end
        // reset in the middle of a frame
        btn_right = 1;
        frame_tick = 1;
        @(posedge clk);
        #1 frame_tick = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1;
        total++; if ({x_blue, y_blue, v_state, busy, frame_done} !== {10'd40, 9'd300, 2'b10, 1'b0, 1'b0}) begin bad++; $display("FAIL midframe_reset got=(%0d,%0d,%b,%b,%b) want=(40,300,10,0,0)", x_blue, y_blue, v_state, busy, frame_done); end
        rst = 0; btn_right = 0;
        model_reset();
        settle();
        run_frame(0, 0, 0, ok);
        total++; if (!ok || y_blue !== 9'd301 || x_blue !== 10'd40) begin bad++; $display("FAIL after_reset_frame got=(%0d,%0d) want=(40,301) ok=%0d", x_blue, y_blue, ok); end
    endtask

    task automatic test_random;
        bit ok, l, r, j;
        apply_reset();
        env_clear();
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                floor_en = 1'($urandom_range(0, 1));
                floor_y  = int'($urandom_range(250, 435));
                ceil_en  = 1'($urandom_range(0, 1));
                ceil_y   = int'($urandom_range(0, 200));
                wr_en    = 1'($urandom_range(0, 1));
                wall_r   = int'($urandom_range(300, 617));
                wl_en    = 1'($urandom_range(0, 1));
                wall_l   = int'($urandom_range(0, 300));
                settle();
            end
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 3) == 0);
            run_frame(l, r, j, ok);
            total++; if (!ok || {x_blue, y_blue, v_state} !== {10'(mx), 9'(my), 2'(mvs)}) begin bad++; $display("FAIL random frame=%0d btn=%0d%0d%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d) ok=%0d", f, l, r, j, x_blue, y_blue, v_state, mx, my, mvs, ok); end
        end
    endtask

    initial begin
        test_reset();
        test_freefall();
        test_land();
        test_jump();
        test_ceiling();
        test_horizontal();
        test_busy_tick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
